// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the multi-cycle set-bit scanner.
package bit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } scan_state_e;

  typedef enum logic {
    DIR_LSB = 1'b0,
    DIR_MSB = 1'b1
  } scan_dir_e;

  // Index width for n items; never collapses to zero bits when n is 1.
  function automatic int pos_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/chunk_prio_enc.sv
// Combinational priority encoder for one CHUNK-wide slice, leading or trailing one.
module chunk_prio_enc
  import bit_scan_pkg::*;
#(
  parameter int CHUNK = 8,
  localparam int OFF_W = pos_width(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             dir,
  output logic [OFF_W-1:0] offset,
  output logic             any
);

  // Later loop iterations win, so the loop order selects the priority direction.
  always_comb begin
    offset = '0;
    any    = |chunk;
    if (dir == DIR_MSB) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (chunk[i]) begin
          offset = OFF_W'(i);
        end else begin
          offset = offset;
        end
      end
    end else begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (chunk[i]) begin
          offset = OFF_W'(i);
        end else begin
          offset = offset;
        end
      end
    end
  end

endmodule

// File: rtl/set_bit_scanner.sv
// Multi-cycle set-bit finder: scans CHUNK bits per cycle in either direction and
// reports the first set bit or enumerates every set bit, one beat per handshake.
module set_bit_scanner
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int POS_W = pos_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb,
  input  logic             in_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_found,
  output logic             out_last
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = pos_width(NCHUNK);
  localparam int OFF_W  = pos_width(CHUNK);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  scan_state_e      state_r, state_n;
  scan_dir_e        dir_r, dir_n;
  logic [WIDTH-1:0] shadow_r, shadow_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [POS_W-1:0] pos_r, pos_n;
  logic             all_r, all_n;
  logic             found_r, found_n;
  logic             last_r, last_n;
  logic             valid_r, valid_n;
  logic             ready_r, ready_n;

  logic [CHUNK-1:0] chunk_s;
  logic [OFF_W-1:0] offset_s;
  logic             any_s;
  logic [POS_W-1:0] hit_pos_s;
  logic [WIDTH-1:0] remain_s;
  logic [WIDTH-1:0] clear_s;
  logic             last_chunk_s;

  assign chunk_s      = shadow_r[int'(idx_r) * CHUNK +: CHUNK];
  assign hit_pos_s    = POS_W'(int'(idx_r) * CHUNK) + POS_W'(offset_s);
  // remain_s looks ahead so out_last is known when the beat is first presented.
  assign remain_s     = shadow_r & ~(ONE << hit_pos_s);
  assign clear_s      = shadow_r & ~(ONE << pos_r);
  assign last_chunk_s = (dir_r == DIR_MSB) ? (idx_r == '0) : (idx_r == TOP_IDX);

  chunk_prio_enc #(.CHUNK(CHUNK)) u_enc (
    .chunk  (chunk_s),
    .dir    (dir_r),
    .offset (offset_s),
    .any    (any_s)
  );

  // Next-state and next-output logic for the IDLE/SCAN/EMIT sequence.
  always_comb begin
    state_n  = state_r;
    dir_n    = dir_r;
    shadow_n = shadow_r;
    idx_n    = idx_r;
    pos_n    = pos_r;
    all_n    = all_r;
    found_n  = found_r;
    last_n   = last_r;
    valid_n  = valid_r;
    ready_n  = ready_r;
    case (state_r)
      IDLE: begin
        if (in_valid && ready_r) begin
          shadow_n = in_data;
          dir_n    = in_msb ? DIR_MSB : DIR_LSB;
          all_n    = in_all;
          idx_n    = in_msb ? TOP_IDX : '0;
          ready_n  = 1'b0;
          state_n  = SCAN;
        end else begin
          ready_n  = 1'b1;
        end
      end
      SCAN: begin
        if (any_s) begin
          pos_n   = hit_pos_s;
          found_n = 1'b1;
          last_n  = all_r ? (remain_s == '0) : 1'b1;
          valid_n = 1'b1;
          state_n = EMIT;
        end else if (last_chunk_s) begin
          pos_n   = '0;
          found_n = 1'b0;
          last_n  = 1'b1;
          valid_n = 1'b1;
          state_n = EMIT;
        end else begin
          idx_n   = (dir_r == DIR_MSB) ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
        end
      end
      EMIT: begin
        if (out_ready) begin
          valid_n = 1'b0;
          if (!all_r || !found_r || last_r) begin
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            shadow_n = clear_s;
            state_n  = SCAN;
          end
        end else begin
          valid_n = 1'b1;
        end
      end
      default: begin
        valid_n = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves the block idle and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      dir_r    <= DIR_LSB;
      shadow_r <= '0;
      idx_r    <= '0;
      pos_r    <= '0;
      all_r    <= 1'b0;
      found_r  <= 1'b0;
      last_r   <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_n;
      dir_r    <= dir_n;
      shadow_r <= shadow_n;
      idx_r    <= idx_n;
      pos_r    <= pos_n;
      all_r    <= all_n;
      found_r  <= found_n;
      last_r   <= last_n;
      valid_r  <= valid_n;
      ready_r  <= ready_n;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_pos   = pos_r;
  assign out_found = found_r;
  assign out_last  = last_r;

endmodule

// File: tb/tb_set_bit_scanner.sv
// Scoreboard bench: a bit-list reference model queues expected beats, a monitor
// checks each output handshake, first-beat latency and stall stability.
module tb_set_bit_scanner;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int POS_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_msb;
  logic             in_all;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic             out_found;
  logic             out_last;

  set_bit_scanner #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_msb    (in_msb),
    .in_all    (in_all),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_found (out_found),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pos;
    bit found;
    bit last;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   manual = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: list the set bits in scan order, then derive the beats from that list.
  function automatic void model(input logic [31:0] d, input bit msb, input bit all);
    int   bits[$];
    exp_t e;
    int   j;
    for (int k = 0; k < WIDTH; k++) begin
      int b = msb ? (WIDTH - 1 - k) : k;
      if (d[b]) bits.push_back(b);
    end
    if (bits.size() == 0) begin
      e = '{pos: 0, found: 1'b0, last: 1'b1, lat: NCHUNK};
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < bits.size(); k++) begin
        if (k > 0 && !all) break;
        j = msb ? (NCHUNK - 1 - bits[k] / CHUNK) : (bits[k] / CHUNK);
        e.pos   = bits[k];
        e.found = 1'b1;
        e.last  = !all || (k == bits.size() - 1);
        e.lat   = (k == 0) ? j + 1 : -1;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic send(input logic [31:0] d, input bit msb, input bit all, input bit use_model);
    int w = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_msb   = msb;
    in_all   = all;
    if (use_model) model(d, msb, all);
    while (in_ready !== 1'b1 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) check("accept_timeout", 32'(w), 32'd0);
    if (use_model) acc_q.push_back(cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_msb   = 1'($urandom);
    in_all   = 1'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() > 0 || in_ready !== 1'b1) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 3000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (out_valid !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) check(name, 32'(out_valid), 32'd1);
  endtask

  // Consumer back-pressure, unless a directed test drives out_ready itself.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!manual) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares beats on handshake, checks first-beat latency and stall stability.
  initial begin
    bit               prev_valid = 1'b0;
    bit               stalled    = 1'b0;
    bit               gap        = 1'b0;
    logic [POS_W-1:0] s_pos;
    logic             s_found;
    logic             s_last;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (gap) begin
        check("gap_after_handshake", 32'(out_valid), 32'd0);
        gap = 1'b0;
      end
      if (out_valid === 1'b1) begin
        check("in_ready_while_busy", 32'(in_ready), 32'd0);
        if (stalled) begin
          check("stall_pos", 32'(out_pos), 32'(s_pos));
          check("stall_found", 32'(out_found), 32'(s_found));
          check("stall_last", 32'(out_last), 32'(s_last));
        end
        if (!prev_valid && exp_q.size() > 0 && exp_q[0].lat >= 0 && acc_q.size() > 0)
          check("first_latency", 32'(cyc - acc_q.pop_front() - 1), 32'(exp_q[0].lat));
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got pos %0d found %0d, expected no beat", out_pos, out_found);
          end else begin
            e = exp_q.pop_front();
            check("pos", 32'(out_pos), 32'(e.pos));
            check("found", 32'(out_found), 32'(e.found));
            check("last", 32'(out_last), 32'(e.last));
          end
          stalled = 1'b0;
          gap     = 1'b1;
        end else begin
          stalled = 1'b1;
          s_pos   = out_pos;
          s_found = out_found;
          s_last  = out_last;
        end
      end else begin
        stalled = 1'b0;
      end
      prev_valid = (out_valid === 1'b1);
    end
  end

  initial begin
    logic [31:0] d;
    // Reset holds the block idle; a request offered during reset must not transfer.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_FFFF;
    in_msb   = 1'b1;
    in_all   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pos", 32'(out_pos), 32'd0);
    check("rst_out_found", 32'(out_found), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    send(32'h0001_0000, 1'b1, 1'b0, 1'b1);
    drain();
    send(32'h8000_0100, 1'b0, 1'b0, 1'b1);
    drain();
    send(32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    send(32'h0000_0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Enumeration with a three-cycle stall on the second beat.
    manual    = 1'b1;
    out_ready = 1'b0;
    send(32'h8000_0011, 1'b1, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      wait_valid("enum_beat_timeout");
      if (b == 1) repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    check("enum_done_in_ready", 32'(in_ready), 32'd1);
    check("enum_queue_empty", 32'(exp_q.size()), 32'd0);
    manual = 1'b0;

    // Reset in the middle of a scan discards the request.
    send(32'h0000_0001, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'd0);
    end
    send(32'h0000_0010, 1'b0, 1'b0, 1'b1);
    drain();

    // Randomized requests, issued back-to-back, with mixed density patterns.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 4))
        0:       d = 32'h0;
        1:       d = 32'h1 << $urandom_range(0, 31);
        2:       d = $urandom & $urandom & $urandom;
        3:       d = $urandom;
        default: d = (32'h1 << $urandom_range(0, 7)) | (32'h8000_0000 >> $urandom_range(0, 7));
      endcase
      send(d, 1'($urandom), 1'($urandom), 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
